// File: rtl/inst_dec_pkg.sv
// Shared definitions for the instruction decode stage: field offsets,
// opcodes that inhibit the register write, and the decoded control bundle.
package inst_dec_pkg;

  localparam int SKID_DEPTH = 2;

  // Upper four opcode bits of instructions that never write the register file.
  localparam logic [3:0] NOWE_OPC_0 = 4'b0111;
  localparam logic [3:0] NOWE_OPC_1 = 4'b1100;
  localparam logic [3:0] NOWE_OPC_2 = 4'b1101;

  typedef struct packed {
    logic regwe;
    logic imm_signed;
  } dec_ctl_t;

  function automatic int opc_lsb(input int inst_w, input int opc_w);
    return inst_w - opc_w;
  endfunction

  function automatic int sel_a_lsb(input int inst_w, input int opc_w, input int reg_aw);
    return inst_w - opc_w - reg_aw;
  endfunction

  function automatic int sel_b_lsb(input int inst_w, input int opc_w, input int reg_aw);
    return inst_w - opc_w - 2 * reg_aw;
  endfunction

  function automatic int sel_d_lsb(input int inst_w, input int opc_w, input int reg_aw);
    return inst_w - opc_w - 3 * reg_aw;
  endfunction

  function automatic dec_ctl_t decode_ctl(input logic [3:0] opc_hi, input logic opc_lo);
    dec_ctl_t c;
    c.regwe      = !((opc_hi == NOWE_OPC_0) || (opc_hi == NOWE_OPC_1) ||
                     (opc_hi == NOWE_OPC_2));
    c.imm_signed = opc_lo;
    return c;
  endfunction

endpackage

// File: rtl/inst_dec_skid.sv
// Two-entry in-order skid buffer with flush. ready is registered and drops
// only when both entries are occupied.
module inst_dec_skid
  import inst_dec_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         ready
);

  localparam logic [1:0] FULL_CNT = 2'(SKID_DEPTH);

  logic [W-1:0] ent0;
  logic [W-1:0] ent1;
  logic [1:0]   cnt;
  logic [1:0]   cnt_nxt;

  assign head  = ent0;
  assign empty = (cnt == 2'd0);

  always_comb begin
    cnt_nxt = cnt;
    if (flush)
      cnt_nxt = 2'd0;
    else if (push && !pop)
      cnt_nxt = cnt + 2'd1;
    else if (pop && !push)
      cnt_nxt = cnt - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= 2'd0;
      ready <= 1'b0;
      ent0  <= '0;
      ent1  <= '0;
    end else begin
      cnt   <= cnt_nxt;
      ready <= (cnt_nxt != FULL_CNT);
      if (!flush) begin
        // ent0 is always the oldest word; ent1 only matters when two are held.
        case ({push, pop})
          2'b10: begin
            if (cnt == 2'd0) ent0 <= push_data;
            else             ent1 <= push_data;
          end
          2'b01: ent0 <= ent1;
          2'b11: begin
            if (cnt == 2'd1) begin
              ent0 <= push_data;
            end else begin
              ent0 <= ent1;
              ent1 <= push_data;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/inst_dec_pipe.sv
// Decode stage: skid buffer, field decode, registered output and an optional
// writeback scoreboard for RAW stalls, enabled by defining INST_DEC_HAZARD_EN.
module inst_dec_pipe
  import inst_dec_pkg::*;
#(
  parameter int INST_W = 16,
  parameter int OPC_W  = 5,
  parameter int REG_AW = 3,
  parameter int IMM_W  = 8,
  parameter int DATA_W = 16,
  parameter int WB_LAT = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [INST_W-1:0] i_inst,
  input  logic              i_flush,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [OPC_W-1:0]  o_opcode,
  output logic [REG_AW-1:0] o_selA,
  output logic [REG_AW-1:0] o_selB,
  output logic [REG_AW-1:0] o_selD,
  output logic [DATA_W-1:0] o_imm,
  output logic              o_regwe,
  output logic              o_stall
);

  localparam int OPC_LSB = opc_lsb(INST_W, OPC_W);
  localparam int A_LSB   = sel_a_lsb(INST_W, OPC_W, REG_AW);
  localparam int B_LSB   = sel_b_lsb(INST_W, OPC_W, REG_AW);
  localparam int D_LSB   = sel_d_lsb(INST_W, OPC_W, REG_AW);

  if (WB_LAT < 1 || WB_LAT > 8) begin : g_bad_wb_lat
    $error("inst_dec_pipe: WB_LAT must be in 1..8");
  end

  // Handshakes: a word moves on a rising edge where valid & ready are both
  // high; valid never waits on ready, and a valid source holds its data
  // stable until the transfer happens.

  logic              skid_empty;
  logic              skid_push;
  logic              skid_pop;
  logic [INST_W-1:0] skid_head;

  logic              accept;
  logic              head_valid;
  logic [INST_W-1:0] head_inst;
  logic              out_free;
  logic              hazard;
  logic              issue;

  logic [OPC_W-1:0]  head_opc;
  logic [REG_AW-1:0] head_a;
  logic [REG_AW-1:0] head_b;
  logic [REG_AW-1:0] head_d;
  logic [IMM_W-1:0]  head_imm_raw;
  logic [DATA_W-1:0] head_imm;
  dec_ctl_t          head_ctl;

  inst_dec_skid #(.W(INST_W)) u_skid (
    .clk       (i_clk),
    .rst       (i_rst),
    .flush     (i_flush),
    .push      (skid_push),
    .pop       (skid_pop),
    .push_data (i_inst),
    .head      (skid_head),
    .empty     (skid_empty),
    .ready     (o_ready)
  );

  assign accept     = i_valid & o_ready & ~i_rst;
  assign head_inst  = skid_empty ? i_inst : skid_head;
  assign head_valid = skid_empty ? accept : 1'b1;
  assign out_free   = ~o_valid | i_ready;
  assign issue      = out_free & head_valid & ~hazard & ~i_flush & ~i_rst;

  // A freshly accepted word bypasses the skid only when it issues directly.
  assign skid_push  = accept & ~i_flush & ~(issue & skid_empty);
  assign skid_pop   = issue & ~skid_empty;

  assign head_opc     = head_inst[OPC_LSB +: OPC_W];
  assign head_a       = head_inst[A_LSB +: REG_AW];
  assign head_b       = head_inst[B_LSB +: REG_AW];
  assign head_d       = head_inst[D_LSB +: REG_AW];
  assign head_imm_raw = head_inst[IMM_W-1:0];
  assign head_ctl     = decode_ctl(head_opc[OPC_W-1 -: 4], head_opc[0]);
  assign head_imm     = head_ctl.imm_signed ?
                        {{(DATA_W-IMM_W){head_imm_raw[IMM_W-1]}}, head_imm_raw} :
                        {{(DATA_W-IMM_W){1'b0}}, head_imm_raw};

`ifdef INST_DEC_HAZARD_EN
  // Index 0 is the newest writeback; an entry is visible for WB_LAT cycles.
  logic              sb_v [WB_LAT];
  logic [REG_AW-1:0] sb_a [WB_LAT];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < WB_LAT; i++) begin
        sb_v[i] <= 1'b0;
        sb_a[i] <= '0;
      end
    end else begin
      sb_v[0] <= issue & head_ctl.regwe;
      sb_a[0] <= head_d;
      for (int i = 1; i < WB_LAT; i++) begin
        sb_v[i] <= sb_v[i-1];
        sb_a[i] <= sb_a[i-1];
      end
    end
  end

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < WB_LAT; i++) begin
      if (sb_v[i] && ((sb_a[i] == head_a) || (sb_a[i] == head_b)))
        hazard = 1'b1;
    end
  end
`else
  assign hazard = 1'b0;
`endif

  assign o_stall = head_valid & hazard & ~i_flush & ~i_rst;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid  <= 1'b0;
      o_opcode <= '0;
      o_selA   <= '0;
      o_selB   <= '0;
      o_selD   <= '0;
      o_imm    <= '0;
      o_regwe  <= 1'b0;
    end else if (i_flush) begin
      o_valid <= 1'b0;
    end else if (issue) begin
      o_valid  <= 1'b1;
      o_opcode <= head_opc;
      o_selA   <= head_a;
      o_selB   <= head_b;
      o_selD   <= head_d;
      o_imm    <= head_imm;
      o_regwe  <= head_ctl.regwe;
    end else if (out_free) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_inst_dec_pipe.sv
// Self-checking bench for inst_dec_pipe: decode vectors, skid/flush/hazard
// sequences and a randomized stream checked against an in-order model.
module tb_inst_dec_pipe;

  logic        clk = 1'b0;
  logic        i_rst, i_valid, i_flush, i_ready;
  logic [15:0] i_inst;
  logic        o_ready, o_valid, o_regwe, o_stall;
  logic [4:0]  o_opcode;
  logic [2:0]  o_selA, o_selB, o_selD;
  logic [15:0] o_imm;
  logic [30:0] dut_pack;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];
  bit mon_en = 1'b0;

`ifdef INST_DEC_HAZARD_EN
  localparam int EXP_STALL    = 3;
  localparam int EXP_LAT      = 4;
  localparam int EXP_FL_STALL = 2;
  localparam int EXP_FL_LAT   = 3;
`else
  localparam int EXP_STALL    = 0;
  localparam int EXP_LAT      = 1;
  localparam int EXP_FL_STALL = 0;
  localparam int EXP_FL_LAT   = 1;
`endif

  always #5 clk = ~clk;

  inst_dec_pipe dut (
    .i_clk    (clk),
    .i_rst    (i_rst),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_inst   (i_inst),
    .i_flush  (i_flush),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_opcode (o_opcode),
    .o_selA   (o_selA),
    .o_selB   (o_selB),
    .o_selD   (o_selD),
    .o_imm    (o_imm),
    .o_regwe  (o_regwe),
    .o_stall  (o_stall)
  );

  assign dut_pack = {o_opcode, o_selA, o_selB, o_selD, o_imm, o_regwe};

  // Reference decode straight from the field rules, using plain arithmetic.
  function automatic logic [30:0] ref_dec(input logic [15:0] inst);
    int v, opc, a, b, d, imm;
    bit we;
    v   = int'(inst);
    opc = v / 2048;
    a   = (v / 256) % 8;
    b   = (v / 32) % 8;
    d   = (v / 4) % 8;
    imm = v % 256;
    if ((opc % 2) == 1 && imm >= 128) imm = imm + 65280;
    we  = !((opc / 2) == 7 || (opc / 2) == 12 || (opc / 2) == 13);
    return {opc[4:0], a[2:0], b[2:0], d[2:0], imm[15:0], we};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1; i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b0; i_inst = '0;
    repeat (3) step();
    check("rst_valid", o_valid, 0);
    check("rst_ready", o_ready, 0);
    check("rst_outs", dut_pack, 0);
    check("rst_stall", o_stall, 0);
    i_rst = 1'b0;
    step();
    check("rst_ready_after", o_ready, 1);
  endtask

  // Present rd (already driven) and count stall cycles and edges until it shows.
  task automatic measure(input logic [15:0] rd, output int stalls, output int lat);
    stalls = 0;
    lat = 0;
    while (lat < 12) begin
      if (o_stall) stalls++;
      step();
      lat++;
      i_valid = 1'b0;
      #1;
      if (o_valid && dut_pack == ref_dec(rd)) break;
    end
  endtask

  // Scoreboard: every accepted word must leave in order with correct decode.
  logic [30:0] prev_pack;
  bit          prev_hold = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_hold) begin
        check("hold_valid", o_valid, 1);
        check("hold_stable", dut_pack, prev_pack);
      end
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL rand_extra_out: got 0x%0h, expected no output", dut_pack);
        end else begin
          check("rand_out", dut_pack, ref_dec(exp_q.pop_front()));
        end
      end
      if (i_valid && o_ready) exp_q.push_back(i_inst);
`ifndef INST_DEC_HAZARD_EN
      check("no_stall", o_stall, 0);
`endif
      prev_hold = o_valid && !i_ready;
      prev_pack = dut_pack;
    end else begin
      prev_hold = 1'b0;
    end
  end

  typedef struct {
    logic [15:0] inst;
    logic [4:0]  opc;
    logic [2:0]  a;
    logic [2:0]  b;
    logic [2:0]  d;
    logic [15:0] imm;
    logic        we;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];
  logic [15:0] sw [3];
  logic [15:0] fw [3];

  initial begin
    int stalls, lat, got, seen;
    bit acc;

    vecs[0] = '{16'h5A64, 5'h0B, 3'd2, 3'd3, 3'd1, 16'h0064, 1'b1};
    vecs[1] = '{16'h7000, 5'h0E, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b0};
    vecs[2] = '{16'hC000, 5'h18, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b0};
    vecs[3] = '{16'hD000, 5'h1A, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b0};
    vecs[4] = '{16'h8000, 5'h10, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b1};
    vecs[5] = '{16'h0414, 5'h00, 3'd4, 3'd0, 3'd5, 16'h0014, 1'b1};
    vecs[6] = '{16'h0F80, 5'h01, 3'd7, 3'd4, 3'd0, 16'hFF80, 1'b1};
    vecs[7] = '{16'h3FFF, 5'h07, 3'd7, 3'd7, 3'd7, 16'hFFFF, 1'b1};
    vecs[8] = '{16'h6CF3, 5'h0D, 3'd4, 3'd7, 3'd4, 16'hFFF3, 1'b1};
    vecs[9] = '{16'hDF7F, 5'h1B, 3'd7, 3'd3, 3'd7, 16'h007F, 1'b0};
    sw = '{16'h7123, 16'hC4A5, 16'hD7FE};
    fw = '{16'h7000, 16'hC000, 16'hD000};

    // Decode vectors, each from reset: one edge from acceptance to output.
    for (int k = 0; k < NV; k++) begin
      do_reset();
      i_ready = 1'b1;
      i_inst  = vecs[k].inst;
      i_valid = 1'b1;
      step();
      i_valid = 1'b0;
      check($sformatf("vec%0d_valid", k), o_valid, 1);
      check($sformatf("vec%0d_fields", k), dut_pack,
            {vecs[k].opc, vecs[k].a, vecs[k].b, vecs[k].d, vecs[k].imm, vecs[k].we});
    end

    // Backpressure: skid fills, ready drops, then all words drain in order.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      i_inst = sw[k];
      i_valid = 1'b1;
      step();
    end
    i_valid = 1'b0;
    check("skid_full_ready", o_ready, 0);
    check("skid_hold_out", dut_pack, ref_dec(sw[0]));
    i_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 10; c++) begin
      if (o_valid) begin
        if (got < 3) check($sformatf("skid_order%0d", got), dut_pack, ref_dec(sw[got]));
        got++;
      end
      step();
    end
    check("skid_count", got, 3);

    // RAW hazard: writer of r5 followed immediately by a reader of r5.
    do_reset();
    i_ready = 1'b1;
    i_inst  = 16'h0414;
    i_valid = 1'b1;
    step();
    check("haz_writer", dut_pack, ref_dec(16'h0414));
    i_inst = 16'h0500;
    #1;
    measure(16'h0500, stalls, lat);
    check("haz_stall_cycles", stalls, EXP_STALL);
    check("haz_latency", lat, EXP_LAT);

    // Flush with a full skid and a held output word.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      i_inst = fw[k];
      i_valid = 1'b1;
      step();
    end
    i_valid = 1'b0;
    check("fl_pre_ready", o_ready, 0);
    check("fl_pre_valid", o_valid, 1);
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    check("fl_valid", o_valid, 0);
    check("fl_ready", o_ready, 1);
    check("fl_stall", o_stall, 0);
    i_inst = 16'h7111;
    i_valid = 1'b1;
    i_flush = 1'b1;
    step();
    i_valid = 1'b0;
    i_flush = 1'b0;
    i_ready = 1'b1;
    seen = 0;
    repeat (5) begin
      if (o_valid) seen++;
      step();
    end
    check("fl_drop_count", seen, 0);

    // Flush leaves in-flight writebacks tracked.
    do_reset();
    i_ready = 1'b1;
    i_inst  = 16'h0414;
    i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    i_inst  = 16'h0500;
    i_valid = 1'b1;
    #1;
    measure(16'h0500, stalls, lat);
    check("fl_sb_stall_cycles", stalls, EXP_FL_STALL);
    check("fl_sb_latency", lat, EXP_FL_LAT);

    // Randomized stream with random backpressure.
    do_reset();
    exp_q.delete();
    mon_en = 1'b1;
    for (int c = 0; c < 400; c++) begin
      i_ready = ($urandom_range(0, 3) != 0);
      if (!i_valid && $urandom_range(0, 1) == 1) begin
        i_valid = 1'b1;
        i_inst  = 16'($urandom_range(0, 65535));
      end
      acc = i_valid & o_ready;
      step();
      if (acc) i_valid = 1'b0;
    end
    i_ready = 1'b1;
    for (int c = 0; c < 100; c++) begin
      acc = i_valid & o_ready;
      step();
      if (acc) i_valid = 1'b0;
      if (!i_valid && !o_valid && exp_q.size() == 0) break;
    end
    mon_en = 1'b0;
    check("rand_drain", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
